// File: rtl/multicycle_control_fsm.sv
// Control unit for a multicycle MIPS-subset datapath (lw, sw, R-type, beq, j, addi).
// Moore-style decode from the state register; only FETCH/MEMREAD/MEMWRITE look at mem_ready.
module multicycle_control_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUsrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       invalid_op
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADDR  = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;
  localparam logic [3:0] S_INVALID  = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [3:0] r_state;
  logic [3:0] w_next_state;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next_state = S_MEMADDR;
          OP_RTYPE:     w_next_state = S_RTYPE_EX;
          OP_BEQ:       w_next_state = S_BRANCH;
          OP_J:         w_next_state = S_JUMP;
          OP_ADDI:      w_next_state = S_ADDI_EX;
          default:      w_next_state = S_INVALID;
        endcase
      end
      S_MEMADDR:  w_next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    w_next_state = S_FETCH;
      S_MEMWRITE: w_next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      S_RTYPE_EX: w_next_state = S_ALU_WB;
      S_ALU_WB:   w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
      S_INVALID:  w_next_state = S_INVALID;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // Output decode; reset gates everything low so FETCH strobes never leak during reset
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    ALUSrcA     = 1'b0;
    ALUsrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    invalid_op  = 1'b0;
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUsrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE:   ALUsrcB = 2'b11;
        S_MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUsrcB = 2'b10;
        end
        S_MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTYPE_EX: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALU_WB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUsrcB = 2'b10;
        end
        S_ADDI_WB:  RegWrite   = 1'b1;
        S_INVALID:  invalid_op = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks each instruction class, wait states,
// the sticky invalid state and asynchronous reset, against hand-computed control words.
module tb_multicycle_control_fsm;

  logic       clock;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0] ALUsrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       invalid_op;

  int n_checks = 0;
  int n_errors = 0;

  // Control word: {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegWrite,
  //                RegDst,ALUSrcA,ALUsrcB[1:0],ALUOp[1:0],PCSource[1:0]}
  localparam logic [15:0] C_FETCH_RDY  = 16'h9410;
  localparam logic [15:0] C_FETCH_WAIT = 16'h1010;
  localparam logic [15:0] C_DECODE     = 16'h0030;
  localparam logic [15:0] C_MEMADDR    = 16'h0060;
  localparam logic [15:0] C_MEMREAD    = 16'h3000;
  localparam logic [15:0] C_MEMWB      = 16'h0300;
  localparam logic [15:0] C_MEMWRITE   = 16'h2800;
  localparam logic [15:0] C_RTYPE_EX   = 16'h0048;
  localparam logic [15:0] C_ALU_WB     = 16'h0180;
  localparam logic [15:0] C_BRANCH     = 16'h4045;
  localparam logic [15:0] C_JUMP       = 16'h8002;
  localparam logic [15:0] C_ADDI_EX    = 16'h0060;
  localparam logic [15:0] C_ADDI_WB    = 16'h0100;
  localparam logic [15:0] C_NONE       = 16'h0000;

  logic [15:0] w_ctrl;
  assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite,
                   RegDst, ALUSrcA, ALUsrcB, ALUOp, PCSource};

  multicycle_control_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUsrcB(ALUsrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .invalid_op(invalid_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive mem_ready, let outputs settle, check the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic mr, input logic [3:0] exp_state,
                      input logic [15:0] exp_ctrl);
    mem_ready = mr;
    #1;
    check({tag, ".state"}, 32'(state), 32'(exp_state));
    check({tag, ".ctrl"}, 32'(w_ctrl), 32'(exp_ctrl));
    check({tag, ".inv"}, 32'(invalid_op), 32'(exp_state == 4'd12));
    check({tag, ".rw_mw"}, 32'(RegWrite & MemWrite), 32'd0);
    @(negedge clock);
  endtask

  initial begin
    reset     = 1'b0;
    opcode    = 6'b100011;
    mem_ready = 1'b1;
    #2;
    check("rst.state", 32'(state), 32'd0);
    check("rst.ctrl", 32'(w_ctrl), 32'(C_NONE));
    check("rst.inv", 32'(invalid_op), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // lw, no waits: 0,1,2,3,4 then back to 0
    opcode = 6'b100011;
    step("lw0", 1'b1, 4'd0, C_FETCH_RDY);
    step("lw1", 1'b1, 4'd1, C_DECODE);
    step("lw2", 1'b1, 4'd2, C_MEMADDR);
    step("lw3", 1'b1, 4'd3, C_MEMREAD);
    step("lw4", 1'b1, 4'd4, C_MEMWB);

    // FETCH stall for 3 cycles, then a jump
    opcode = 6'b000010;
    step("fw0", 1'b0, 4'd0, C_FETCH_WAIT);
    step("fw1", 1'b0, 4'd0, C_FETCH_WAIT);
    step("fw2", 1'b0, 4'd0, C_FETCH_WAIT);
    step("fw3", 1'b1, 4'd0, C_FETCH_RDY);
    step("j1", 1'b1, 4'd1, C_DECODE);
    step("j9", 1'b1, 4'd9, C_JUMP);

    // beq
    opcode = 6'b000100;
    step("beq0", 1'b1, 4'd0, C_FETCH_RDY);
    step("beq1", 1'b1, 4'd1, C_DECODE);
    step("beq8", 1'b1, 4'd8, C_BRANCH);

    // sw with two wait cycles in MEMWRITE
    opcode = 6'b101011;
    step("sw0", 1'b1, 4'd0, C_FETCH_RDY);
    step("sw1", 1'b1, 4'd1, C_DECODE);
    step("sw2", 1'b1, 4'd2, C_MEMADDR);
    step("sw5a", 1'b0, 4'd5, C_MEMWRITE);
    step("sw5b", 1'b0, 4'd5, C_MEMWRITE);
    step("sw5c", 1'b1, 4'd5, C_MEMWRITE);

    // R-type
    opcode = 6'b000000;
    step("rt0", 1'b1, 4'd0, C_FETCH_RDY);
    step("rt1", 1'b1, 4'd1, C_DECODE);
    step("rt6", 1'b1, 4'd6, C_RTYPE_EX);
    step("rt7", 1'b1, 4'd7, C_ALU_WB);

    // addi
    opcode = 6'b001000;
    step("ai0", 1'b1, 4'd0, C_FETCH_RDY);
    step("ai1", 1'b1, 4'd1, C_DECODE);
    step("ai10", 1'b1, 4'd10, C_ADDI_EX);
    step("ai11", 1'b1, 4'd11, C_ADDI_WB);

    // lw with one MEMREAD wait
    opcode = 6'b100011;
    step("lww0", 1'b1, 4'd0, C_FETCH_RDY);
    step("lww1", 1'b1, 4'd1, C_DECODE);
    step("lww2", 1'b1, 4'd2, C_MEMADDR);
    step("lww3a", 1'b0, 4'd3, C_MEMREAD);
    step("lww3b", 1'b1, 4'd3, C_MEMREAD);
    step("lww4", 1'b1, 4'd4, C_MEMWB);

    // Unsupported opcode: sticky INVALID
    opcode = 6'b111111;
    step("inv0", 1'b1, 4'd0, C_FETCH_RDY);
    step("inv1", 1'b1, 4'd1, C_DECODE);
    for (int i = 0; i < 10; i++) step("inv12", 1'b1, 4'd12, C_NONE);
    #2 reset = 1'b0;
    #1;
    check("invrst.state", 32'(state), 32'd0);
    check("invrst.inv", 32'(invalid_op), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step("post_inv", 1'b1, 4'd0, C_FETCH_RDY);

    // Asynchronous reset in the middle of MEMREAD
    opcode = 6'b100011;
    step("ar1", 1'b1, 4'd1, C_DECODE);
    step("ar2", 1'b1, 4'd2, C_MEMADDR);
    mem_ready = 1'b0;
    #1;
    check("ar3.state", 32'(state), 32'd3);
    #2 reset = 1'b0;
    #1;
    check("ar.state", 32'(state), 32'd0);
    check("ar.ctrl", 32'(w_ctrl), 32'(C_NONE));
    check("ar.inv", 32'(invalid_op), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    step("ar_rel", 1'b1, 4'd0, C_FETCH_RDY);
    step("ar_dec", 1'b1, 4'd1, C_DECODE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
